// File: rtl/decode_fsm_ctrl.sv
// Sequencing controller for the serial decode FSM: INIT warm-up, IDLE start-bit hunt,
// DECODE frame shift-in with pattern match, frame/match pulses and a saturating match counter.
module decode_fsm_ctrl #(
  parameter int unsigned           INIT_CYCLES   = 4,
  parameter int unsigned           FRAME_BITS    = 8,
  parameter logic [FRAME_BITS-1:0] MATCH_PATTERN = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pi_i,
  output logic [1:0]            state_o,
  output logic                  po_o,
  output logic [FRAME_BITS-1:0] frame_data_o,
  output logic                  frame_valid_o,
  output logic [7:0]            match_cnt_o
);

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StDecode = 2'd1,
    StIdle   = 2'd2
  } fsmstate_e;

  localparam logic [7:0] InitLast = 8'(INIT_CYCLES - 1);
  localparam logic [5:0] BitLast  = 6'(FRAME_BITS - 1);

  fsmstate_e             state_q, state_d;
  logic [7:0]            init_cnt_q, init_cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  po_q, po_d;
  logic [7:0]            match_cnt_q, match_cnt_d;
  logic [FRAME_BITS-1:0] shift_nxt;

  // MSB-first: the newest bit always lands in bit 0.
  assign shift_nxt = (shift_q << 1) | FRAME_BITS'(pi_i);

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    po_d          = 1'b0;
    match_cnt_d   = match_cnt_q;

    case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 8'd1;
        if (init_cnt_q == InitLast) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (pi_i) begin
          state_d   = StDecode;
          bit_cnt_d = '0;
        end
      end
      StDecode: begin
        shift_d   = shift_nxt;
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == BitLast) begin
          state_d       = StIdle;
          frame_data_d  = shift_nxt;
          frame_valid_d = 1'b1;
          if (shift_nxt == MATCH_PATTERN) begin
            po_d = 1'b1;
            if (match_cnt_q != 8'hFF) begin
              match_cnt_d = match_cnt_q + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      po_q          <= 1'b0;
      match_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      po_q          <= po_d;
      match_cnt_q   <= match_cnt_d;
    end
  end

  assign state_o       = state_q;
  assign po_o          = po_q;
  assign frame_data_o  = frame_data_q;
  assign frame_valid_o = frame_valid_q;
  assign match_cnt_o   = match_cnt_q;

endmodule

// File: tb/tb_decode_fsm_ctrl.sv
// Bench for decode_fsm_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked cycle by cycle against a frame-level reference model.
module tb_decode_fsm_ctrl;

  localparam int unsigned INIT = 4;
  localparam int unsigned FB   = 8;
  localparam logic [7:0]  PAT  = 8'hA5;

  localparam logic [1:0] S_INIT = 2'd0, S_DEC = 2'd1, S_IDLE = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pi;
  logic [1:0] state;
  logic       po;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic [7:0] match_cnt;
  logic [19:0] outs;

  decode_fsm_ctrl #(
    .INIT_CYCLES  (INIT),
    .FRAME_BITS   (FB),
    .MATCH_PATTERN(PAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pi_i         (pi),
    .state_o      (state),
    .po_o         (po),
    .frame_data_o (frame_data),
    .frame_valid_o(frame_valid),
    .match_cnt_o  (match_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {state, frame_valid, po, frame_data, match_cnt};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_v  = 0;
  int prev_v  = 0;
  int n_po    = 0;

  // Reference model: counts edges since reset, collects frame bits in a queue.
  int         m_edges;
  bit         m_dec;
  bit         bitq[$];
  logic [1:0] m_state;
  bit         m_valid, m_po;
  logic [7:0] m_data, m_cnt;

  function automatic logic [19:0] model_outs();
    return {m_state, m_valid, m_po, m_data, m_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_dec   = 0;
    bitq.delete();
    m_state = S_INIT;
    m_valid = 0;
    m_po    = 0;
    m_data  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input bit p);
    int unsigned v;
    m_valid = 0;
    m_po    = 0;
    if (m_edges < INIT) begin
      m_edges++;
      m_state = (m_edges >= INIT) ? S_IDLE : S_INIT;
    end else if (!m_dec) begin
      if (p) begin
        m_dec = 1;
        bitq.delete();
        m_state = S_DEC;
      end
    end else begin
      bitq.push_back(p);
      if (bitq.size() == FB) begin
        v = 0;
        foreach (bitq[i]) v = v * 2 + bitq[i];
        m_data  = 8'(v);
        m_valid = 1;
        m_po    = (8'(v) == PAT);
        if (m_po && m_cnt < 255) m_cnt = m_cnt + 1;
        m_dec   = 0;
        m_state = S_IDLE;
      end
    end
  endtask

  task automatic tick(input bit p);
    pi = p;
    @(posedge clk);
    #1;
    cyc++;
    model_step(p);
    check("model", 32'(outs), 32'(model_outs()));
    if (frame_valid) begin
      prev_v = last_v;
      last_v = cyc;
    end
    if (po) n_po++;
  endtask

  // Called 1 time unit after an edge (or at time 0); releases reset on the falling edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_outs", 32'(outs), 32'd0);
    #3;
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v);
    tick(1'b1);
    for (int i = FB - 1; i >= 0; i--) tick(v[i]);
  endtask

  typedef struct {
    bit         pi;
    logic [1:0] st;
    bit         fv;
    bit         po;
    logic [7:0] data;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(bit p, logic [1:0] st, bit fv, bit pov, logic [7:0] d,
                              logic [7:0] c);
    vec_t v;
    v.pi = p; v.st = st; v.fv = fv; v.po = pov; v.data = d; v.cnt = c;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [7:0] a5;
    a5 = PAT;
    pi = 1'b1;

    // Reset release with pi high, then the first 0xA5 frame and the quiet cycle after it.
    for (int i = 0; i < 3; i++) tbl[i] = mk(1'b1, S_INIT, 0, 0, 8'h00, 8'h00);
    tbl[3] = mk(1'b1, S_IDLE, 0, 0, 8'h00, 8'h00);
    tbl[4] = mk(1'b1, S_DEC, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++) tbl[5 + i] = mk(a5[7 - i], S_DEC, 0, 0, 8'h00, 8'h00);
    tbl[12] = mk(a5[0], S_IDLE, 1, 1, 8'hA5, 8'h01);
    tbl[13] = mk(1'b0, S_IDLE, 0, 0, 8'hA5, 8'h01);

    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].pi);
      check($sformatf("vec%0d", i), 32'(outs),
            32'({tbl[i].st, tbl[i].fv, tbl[i].po, tbl[i].data, tbl[i].cnt}));
    end

    // Non-matching frame.
    send_frame(8'h5A);
    check("nomatch_outs", 32'(outs), 32'({S_IDLE, 1'b1, 1'b0, 8'h5A, 8'h01}));

    // Back-to-back matching frames, no idle gap.
    send_frame(8'hA5);
    send_frame(8'hA5);
    check("b2b_spacing", 32'(last_v - prev_v), 32'd9);
    check("b2b_cnt", 32'(match_cnt), 32'd3);
    tick(1'b0);
    check("pulse_low", 32'({frame_valid, po}), 32'd0);

    // Reset after three data bits aborts the frame.
    tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1);
    do_reset();
    tick(1'b1); tick(1'b1); tick(1'b1);
    check("reinit_state", 32'(state), 32'(S_INIT));
    tick(1'b0);
    check("reinit_idle", 32'(state), 32'(S_IDLE));
    check("abort_no_frame", 32'({frame_valid, frame_data, match_cnt}), 32'd0);

    // Saturation over 300 consecutive matches.
    n_po = 0;
    repeat (300) send_frame(8'hA5);
    check("sat_cnt", 32'(match_cnt), 32'd255);
    check("sat_po_count", 32'(n_po), 32'd300);

    // Randomized traffic with occasional resets.
    repeat (200) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r < 6) begin
        send_frame(8'hA5);
      end else if (r < 11) begin
        send_frame(8'($urandom));
      end else begin
        repeat ($urandom_range(1, 12)) tick(1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_fsm_ctrl.md
Name: decode_fsm_ctrl

Overview:
Sequencing controller for the serial decode FSM. It drives the INIT/DECODE/IDLE state seen on the fsm interface. After reset it holds INIT for a fixed warm-up, then waits in IDLE for a start bit on pi. In DECODE it shifts a fixed-length frame in from pi and flags a match against a programmed pattern on po. It sits on the DUT side of the fsm interface and provides the state the testbench samples.

Parameters:
INIT_CYCLES, 4, number of clk edges spent in INIT after reset release; legal range 1..255.
FRAME_BITS, 8, data bits per frame, received MSB first; legal range 1..32.
MATCH_PATTERN, 8'hA5, frame value that raises po; width FRAME_BITS.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
pi  input  1  serial input, sampled on each posedge clk.
state  output  2  registered current state, fsmstate_e encoding: INIT=0, DECODE=1, IDLE=2.
po  output  1  one-cycle pulse: the completed frame equals MATCH_PATTERN.
frame_data  output  FRAME_BITS  last completed frame; held until the next frame completes.
frame_valid  output  1  one-cycle pulse: a frame completed.
match_cnt  output  8  count of matching frames; saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All outputs are registered.
- While reset is high: state=INIT, po=0, frame_valid=0, frame_data=0, match_cnt=0, internal init counter=0, bit counter=0, shift register=0.
- INIT:
  - init counter increments each edge; pi is ignored.
  - On the edge where init counter == INIT_CYCLES-1, next state is IDLE.
  - So state reads IDLE after the INIT_CYCLES-th edge following reset release.
- IDLE:
  - pi sampled each edge.
  - pi=1 (start bit) moves state to DECODE on that edge and clears the bit counter.
  - pi=0 keeps state at IDLE.
- DECODE:
  - Each edge: shift_reg <= {shift_reg[FRAME_BITS-2:0], pi}; bit counter increments.
  - The edge that samples bit FRAME_BITS-1 is the completion edge. On that edge:
    - state <= IDLE.
    - frame_data <= the assembled value (final bit included).
    - frame_valid <= 1.
    - po <= 1 iff the assembled value == MATCH_PATTERN.
    - On a match, match_cnt <= match_cnt+1 unless it is already 255.
- po and frame_valid return to 0 on the next edge. They never stay high for two consecutive cycles.
- Frame timing: start bit at edge S, data at edges S+1..S+FRAME_BITS, pulses visible after edge S+FRAME_BITS.
- Back-to-back frames: a start bit may arrive on the edge immediately after the completion edge (S+FRAME_BITS+1). No idle gap is required.
- pi values in DECODE are data and are never treated as start bits.
- Reset during DECODE: the frame is aborted, no frame_valid or po is produced, all registers take their reset values, and the INIT sequence restarts after release.
- match_cnt does not wrap. frame_data is never updated by an aborted frame.
- State encodings 3 and up are unreachable. If one is ever decoded, next state is INIT.

Test Plan:
1. Release reset with pi held at 1 -> state=INIT for edges 1..4, IDLE after edge 4, DECODE after edge 5; no pulses during INIT.
2. From IDLE, drive start bit then 1,0,1,0,0,1,0,1 (0xA5) -> after the 8th data edge: frame_valid=1, po=1, frame_data=0xA5, match_cnt=1, state=IDLE. Both pulses are low on the following cycle.
3. Drive start bit then 0x5A -> frame_valid pulses, po stays 0, frame_data=0x5A, match_cnt unchanged.
4. Send two 0xA5 frames with the second start bit on the edge right after the first completion -> two frame_valid/po pulses 9 cycles apart; match_cnt increases by 2.
5. Assert reset after 3 data bits of a frame -> immediately state=INIT with all outputs 0 and no frame_valid. After release, 4 INIT edges, then IDLE.
6. Send 300 consecutive 0xA5 frames -> match_cnt reaches 255 and holds; po still pulses on every frame.
